// File: rtl/huff_pkg.sv
// Shared types and sizes for the Huffman encoder/decoder pair.
package huff_pkg;
    localparam int W_NUM   = 8;
    localparam int W_BITS  = 3;
    localparam int MAX_LEN = W_NUM - 1;
    localparam int N_NODES = 2 * W_NUM - 1;

    typedef logic [2:0]          sym_t;
    typedef logic [W_BITS+2:0]   wsum_t;
    typedef logic [MAX_LEN-1:0]  code_t;
    typedef logic [2:0]          len_t;
    typedef logic [3:0]          nid_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BUILD,
        ST_DECODE
    } state_t;
endpackage

// File: rtl/huff_min2.sv
// Picks the two lightest live nodes; equal weights resolve to the smaller node ID.
module huff_min2
    import huff_pkg::*;
(
    input  wsum_t              node_w [N_NODES],
    input  logic [N_NODES-1:0] live,
    output nid_t               idx_a,
    output nid_t               idx_b
);
    wsum_t best_a, best_b;
    logic  found_a, found_b;

    // Strict less-than while scanning upward keeps the lower ID on ties.
    always_comb begin
        idx_a   = '0;
        best_a  = '0;
        found_a = 1'b0;
        for (int i = 0; i < N_NODES; i++) begin
            if (live[i] && (!found_a || node_w[i] < best_a)) begin
                found_a = 1'b1;
                best_a  = node_w[i];
                idx_a   = nid_t'(i);
            end
        end
        idx_b   = '0;
        best_b  = '0;
        found_b = 1'b0;
        for (int i = 0; i < N_NODES; i++) begin
            if (live[i] && nid_t'(i) != idx_a && (!found_b || node_w[i] < best_b)) begin
                found_b = 1'b1;
                best_b  = node_w[i];
                idx_b   = nid_t'(i);
            end
        end
    end
endmodule

// File: rtl/huffman_dec.sv
// Serial Huffman decoder: rebuilds the code table from 8 weights, then decodes root-first bits.
// Define HUFF_DEC_ERR_EN to get the out_err pulse on truncated/unmatched codewords.
//
// state  | meaning
// IDLE   | waiting for weight 0
// LOAD   | capturing weights 1..7
// BUILD  | seven merge cycles, in_ready low
// DECODE | shifting codeword bits and matching against the table
module huffman_dec
    import huff_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [W_BITS-1:0] in_weight,
    input  logic              in_code,
    output logic              in_ready,
    output logic              out_valid,
    output logic [2:0]        out_symbol,
    output logic              out_err
);
    state_t             state_q, state_d;
    sym_t               ld_idx_q;
    nid_t               ld_id;
    logic [2:0]         bld_tmr_q;
    logic               got_bit_q;
    logic [MAX_LEN-2:0] acc_q;
    len_t               cnt_q;
    wsum_t              node_w [N_NODES];
    logic [W_NUM-1:0]   node_m [N_NODES];
    logic [N_NODES-1:0] live_q;
    code_t              code_q [W_NUM];
    len_t               len_q  [W_NUM];
    nid_t               pick_a, pick_b, new_id;
    logic               accept, hit, ovf;
    code_t              acc_nxt;
    len_t               cnt_nxt;
    sym_t               hit_sym;
`ifdef HUFF_DEC_ERR_EN
    logic               err_q;
    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    huff_min2 u_min2 (
        .node_w (node_w),
        .live   (live_q),
        .idx_a  (pick_a),
        .idx_b  (pick_b)
    );

    assign accept  = in_valid & in_ready;
    assign ld_id   = {1'b0, ld_idx_q};
    assign new_id  = 4'd14 - {1'b0, bld_tmr_q};
    assign acc_nxt = {acc_q, in_code};
    assign cnt_nxt = cnt_q + len_t'(1);
    assign ovf     = (cnt_nxt == len_t'(MAX_LEN)) && !hit;

    always_comb begin
        hit     = 1'b0;
        hit_sym = '0;
        for (int i = 0; i < W_NUM; i++) begin
            if (len_q[i] == cnt_nxt && code_q[i] == acc_nxt) begin
                hit     = 1'b1;
                hit_sym = sym_t'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_LOAD;
            ST_LOAD:   if (accept && ld_idx_q == sym_t'(W_NUM - 1)) state_d = ST_BUILD;
            ST_BUILD:  if (bld_tmr_q == '0) state_d = ST_DECODE;
            ST_DECODE: if (!in_valid && got_bit_q) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            in_ready <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d != ST_BUILD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_idx_q   <= '0;
            bld_tmr_q  <= '0;
            got_bit_q  <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            live_q     <= '0;
            out_valid  <= 1'b0;
            out_symbol <= '0;
            for (int j = 0; j < N_NODES; j++) begin
                node_w[j] <= '0;
                node_m[j] <= '0;
            end
            for (int j = 0; j < W_NUM; j++) begin
                code_q[j] <= '0;
                len_q[j]  <= '0;
            end
`ifdef HUFF_DEC_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            out_valid  <= 1'b0;
            out_symbol <= '0;
`ifdef HUFF_DEC_ERR_EN
            err_q      <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: if (accept) begin
                    for (int j = 0; j < N_NODES; j++) begin
                        node_w[j] <= '0;
                        node_m[j] <= '0;
                    end
                    for (int j = 0; j < W_NUM; j++) begin
                        code_q[j] <= '0;
                        len_q[j]  <= '0;
                    end
                    node_w[0] <= wsum_t'(in_weight);
                    node_m[0] <= W_NUM'(1);
                    live_q    <= N_NODES'(1);
                    ld_idx_q  <= sym_t'(1);
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    got_bit_q <= 1'b0;
                end
                ST_LOAD: if (accept) begin
                    node_w[ld_id] <= wsum_t'(in_weight);
                    node_m[ld_id] <= W_NUM'(1) << ld_idx_q;
                    live_q[ld_id] <= 1'b1;
                    ld_idx_q      <= ld_idx_q + sym_t'(1);
                    bld_tmr_q     <= 3'd6;
                end
                ST_BUILD: begin
                    node_w[new_id] <= node_w[pick_a] + node_w[pick_b];
                    node_m[new_id] <= node_m[pick_a] | node_m[pick_b];
                    live_q[pick_a] <= 1'b0;
                    live_q[pick_b] <= 1'b0;
                    live_q[new_id] <= 1'b1;
                    // Codes grow leaf-to-root, so each new bit lands above the existing ones.
                    for (int i = 0; i < W_NUM; i++) begin
                        if (node_m[pick_a][i]) begin
                            len_q[i] <= len_q[i] + len_t'(1);
                        end else if (node_m[pick_b][i]) begin
                            code_q[i] <= code_q[i] | (code_t'(1) << len_q[i]);
                            len_q[i]  <= len_q[i] + len_t'(1);
                        end
                    end
                    if (bld_tmr_q != '0) bld_tmr_q <= bld_tmr_q - 3'd1;
                end
                ST_DECODE: begin
                    if (accept) begin
                        got_bit_q <= 1'b1;
                        if (hit) begin
                            out_valid  <= 1'b1;
                            out_symbol <= hit_sym;
                            acc_q      <= '0;
                            cnt_q      <= '0;
                        end else if (ovf) begin
                            acc_q <= '0;
                            cnt_q <= '0;
`ifdef HUFF_DEC_ERR_EN
                            err_q <= 1'b1;
`endif
                        end else begin
                            // A 7th bit always ends the codeword, so only 6 are ever held.
                            acc_q <= acc_nxt[MAX_LEN-2:0];
                            cnt_q <= cnt_nxt;
                        end
                    end else if (!in_valid && got_bit_q) begin
                        acc_q <= '0;
                        cnt_q <= '0;
`ifdef HUFF_DEC_ERR_EN
                        if (cnt_q != '0) err_q <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_huffman_dec.sv
// Directed bench for huffman_dec with hand-derived code tables and expected symbols.
module tb_huffman_dec;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [2:0] in_weight;
    logic       in_code;
    logic       in_ready;
    logic       out_valid;
    logic [2:0] out_symbol;
    logic       out_err;

    int         checks = 0;
    int         errors = 0;
    int         n;
    logic [2:0] wt [8];
    logic       exp_err;

    huffman_dec dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_weight  (in_weight),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_symbol (out_symbol),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Loads wt[0..7]; hold keeps in_valid high (with in_code=1) through BUILD.
    task automatic load_w(input logic hold);
        chk("load_ready", 8'(in_ready), 8'd1);
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_weight = wt[i];
            in_code   = 1'b1;
            step;
        end
        in_valid  = hold;
        in_weight = '0;
        chk("build_ready_low", 8'(in_ready), 8'd0);
        n = 0;
        while (!in_ready && n < 20) begin
            step;
            n++;
        end
        chk("build_latency", 8'(n), 8'd7);
    endtask

    task automatic bit_chk(input logic b, input logic exp_v, input logic [2:0] exp_s);
        in_valid = 1'b1;
        in_code  = b;
        step;
        chk("out_valid", 8'(out_valid), 8'(exp_v));
        chk("out_symbol", 8'(out_symbol), 8'(exp_s));
        chk("out_err_quiet", 8'(out_err), 8'd0);
    endtask

    task automatic drop(input logic e);
        in_valid = 1'b0;
        in_code  = 1'b0;
        step;
        chk("drop_valid", 8'(out_valid), 8'd0);
        chk("drop_err", 8'(out_err), 8'(e));
        step;
        chk("drop_err_clear", 8'(out_err), 8'd0);
        chk("idle_ready", 8'(in_ready), 8'd1);
    endtask

    initial begin
`ifdef HUFF_DEC_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_weight = '0;
        in_code   = 1'b0;
        step;
        step;
        chk("rst_ready", 8'(in_ready), 8'd0);
        chk("rst_valid", 8'(out_valid), 8'd0);
        chk("rst_symbol", 8'(out_symbol), 8'd0);
        chk("rst_err", 8'(out_err), 8'd0);
        rst_n = 1'b1;
        chk("ready_before_edge", 8'(in_ready), 8'd0);
        step;
        chk("ready_after_edge", 8'(in_ready), 8'd1);

        // All weights 1: every code is 3 bits, symbol s has code s.
        wt = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        load_w(1'b0);
        bit_chk(1'b0, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b1, 3'd0);
        bit_chk(1'b1, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b0, 3'd0);
        bit_chk(1'b1, 1'b1, 3'd5);
        bit_chk(1'b1, 1'b0, 3'd0);
        bit_chk(1'b1, 1'b0, 3'd0);
        bit_chk(1'b1, 1'b1, 3'd7);
        drop(1'b0);

        // Weights 7,1..1: sym0="0", sym7="100", sym1="1010".
        wt = '{3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        load_w(1'b0);
        bit_chk(1'b0, 1'b1, 3'd0);
        bit_chk(1'b0, 1'b1, 3'd0);
        bit_chk(1'b1, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b1, 3'd7);
        bit_chk(1'b1, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b0, 3'd0);
        bit_chk(1'b1, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b1, 3'd1);
        drop(1'b0);

        // Truncated codeword "10" with the all-ones table.
        wt = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        load_w(1'b0);
        bit_chk(1'b1, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b0, 3'd0);
        drop(exp_err);

        // in_valid held through BUILD, then reset mid-DECODE.
        wt = '{3'd7, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
        load_w(1'b1);
        bit_chk(1'b0, 1'b1, 3'd0);
        bit_chk(1'b1, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b1, 3'd7);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("async_rst_valid", 8'(out_valid), 8'd0);
        chk("async_rst_symbol", 8'(out_symbol), 8'd0);
        chk("async_rst_ready", 8'(in_ready), 8'd0);
        step;
        rst_n = 1'b1;
        step;
        chk("post_rst_ready", 8'(in_ready), 8'd1);

        // Weights 3,0..0: sym0="1", sym7="000", sym5="0110".
        wt = '{3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        load_w(1'b0);
        bit_chk(1'b1, 1'b1, 3'd0);
        bit_chk(1'b0, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b1, 3'd7);
        bit_chk(1'b0, 1'b0, 3'd0);
        bit_chk(1'b1, 1'b0, 3'd0);
        bit_chk(1'b1, 1'b0, 3'd0);
        bit_chk(1'b0, 1'b1, 3'd5);
        drop(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
